secure_tx_framer: RTL and testbench
===================================

Name: secure_tx_framer

Overview:
- Sits between the payload source and the UART transmitter, directly downstream of the LFSR key generator.
- Per frame: requests a fresh key, buffers the payload, then emits SOF, LEN, payload, CRC-16 hi and CRC-16 lo to UART TX.
- The CRC is seeded by the key generator's crc_key.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame; legal range 1..255; buffer depth.
- SOF_BYTE, 8'h7E: start-of-frame byte.

Ports:
- clk  in  1  system clock (3.125 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- key_gen  out  1  key request to keygen; registered single-cycle pulse.
- key_valid  in  1  keygen key-valid level.
- crc_key  in  16  CRC seed from keygen.
- aes_key  in  128  key from keygen; used only with SCRAMBLE_EN.
- s_data  in  8  payload byte.
- s_valid  in  1  payload valid.
- s_last  in  1  final payload byte of the frame.
- s_ready  out  1  framer accepts payload.
- m_data  out  8  byte to UART TX.
- m_valid  out  1  m_data valid.
- m_ready  in  1  UART TX accepts byte.
- frame_busy  out  1  high from leaving IDLE until the CRC lo byte is accepted.
- err_overflow  out  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Behaviour:
- Reset values: key_gen=0, s_ready=0, m_valid=0, m_data=0, frame_busy=0, err_overflow=0, state=IDLE, count=0, crc=0. All outputs registered.
- Reset mid-frame aborts immediately; buffered bytes are discarded; no partial frame resumes.
- Transfers: payload transfer when s_valid&s_ready; output transfer when m_valid&m_ready.
- Output stability: m_data/m_valid are held stable while m_valid&!m_ready.
- States:
  - IDLE: s_ready=0. When s_valid=1 -> REQ_KEY, frame_busy<=1.
  - REQ_KEY: key_gen<=1 for exactly one cycle -> KEY_WAIT with seen_low cleared.
  - KEY_WAIT: set seen_low when key_valid=0. When seen_low && key_valid=1: latch crc_key into crc, latch aes_key -> LOAD. A stale key_valid held high from the previous key is never used.
  - LOAD: s_ready=1. Each transfer writes buffer[count] and increments count.
    - s_last=1 -> SEND_SOF.
    - count reaching MAX_LEN without s_last: err_overflow pulses, frame closes -> SEND_SOF. Remaining input bytes belong to the next frame.
    - s_ready drops the cycle after the closing transfer.
  - SEND_SOF: m_data=SOF_BYTE.
  - SEND_LEN: m_data=count (1..MAX_LEN).
  - SEND_PAY: m_data=buffer[idx], idx 0..count-1.
  - SEND_CRC_H: m_data=crc[15:8].
  - SEND_CRC_L: m_data=crc[7:0].
  - Each SEND state advances only on an output transfer. After the CRC_L transfer -> IDLE, frame_busy<=0.
  - m_valid is continuous across SEND states: the next byte is presented the cycle after each accept, so there are no bubbles.
- CRC:
  - CRC-16-CCITT, poly 0x1021, MSB-first, no reflection, no final XOR.
  - Init = latched crc_key.
  - Updated one full byte per cycle on each SEND_PAY transfer only; SOF and LEN are excluded.
  - Computed over bytes as transmitted.
- Latency:
  - Key wait depends on keygen: ≥ LFSR run length + 2 cycles after key_gen.
  - SOF is presented the cycle after the closing payload transfer.
- Simultaneous events: input arriving while in a SEND state is back-pressured (s_ready=0). No overlap between frames.

Optional Feature:
- Macro: SECURE_TX_FRAMER_SCRAMBLE_EN.
- Defined: payload byte i is transmitted as buffer[i] XOR aes_key_latched[8*(i mod 16) +: 8], so byte 0 uses bits [7:0]. The CRC covers the scrambled bytes.
- Undefined: payload is sent in plain; the aes_key input is unused and its latch is not synthesized.

Test Plan:
- Basic frame: SCRAMBLE off, crc_key=16'hFFFF, payload "123456789" with s_last on '9', m_ready=1 -> m stream 7E 09 31 32 33 34 35 36 37 38 39 29 B1; exactly one key_gen pulse.
- Alternate seed: crc_key=16'h0000, same payload -> trailing CRC bytes 31 C3.
- Overflow: MAX_LEN=4, send 6 bytes with no s_last -> frame 7E 04 b0 b1 b2 b3 crcH crcL; err_overflow pulses once; bytes 4-5 start a second frame with a second key_gen pulse.
- Stale key_valid: hold key_valid=1 from the previous key; the model drops it 2 cycles after key_gen, then raises it with a new crc_key=16'h1D0F -> framer latches the new seed, not the stale one.
- Backpressure: m_ready toggled randomly -> m_data stable while stalled; byte sequence identical to the m_ready=1 run.
- Reset mid-frame: assert rst_n=0 during SEND_PAY -> all outputs at reset values; next frame after release is correct and complete.
- SCRAMBLE on, aes_key=128'h0F0E..0100, payload 00 00 -> transmitted payload 00 01; CRC computed over 00 01.

Source files
------------

// File: rtl/secure_tx_framer.sv
// rtl/secure_tx_framer.sv - keyed payload framer: SOF, LEN, payload, CRC-16 toward UART TX
// Optional payload scrambling with the latched aes_key: define SECURE_TX_FRAMER_SCRAMBLE_EN.
module secure_tx_framer #(
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] SOF_BYTE = 8'h7E
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         key_gen,
  input  logic         key_valid,
  input  logic [15:0]  crc_key,
  input  logic [127:0] aes_key,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         frame_busy,
  output logic         err_overflow
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE, REQ_KEY, KEY_WAIT, LOAD,
    SEND_SOF, SEND_LEN, SEND_PAY, SEND_CRC_H, SEND_CRC_L
  } state_t;

  state_t         state, state_d;
  logic [7:0]     count, count_d;
  logic [7:0]     idx, idx_d;
  logic [15:0]    crc, crc_d;
  logic           seen_low, seen_low_d;
  logic           key_gen_d, s_ready_d, m_valid_d, frame_busy_d, err_overflow_d;
  logic [7:0]     m_data_d;
  logic           buf_we;
  logic [8:0]     count_inc;
  logic [15:0]    crc_nxt;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     pay_next;
  logic [7:0]     buffer [MAX_LEN];

  // One full byte of CRC-16-CCITT (poly 0x1021), MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  assign count_inc = {1'b0, count} + 9'd1;
  // The CRC runs over the byte actually on m_data, so scrambled bytes are covered.
  assign crc_nxt   = crc16_byte(crc, m_data);

`ifdef SECURE_TX_FRAMER_SCRAMBLE_EN
  logic [127:0] aes_key_q;
  logic [3:0]   key_sel;

  // Capture the scramble key together with the CRC seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_key_q <= '0;
    end else if (state == KEY_WAIT && seen_low && key_valid) begin
      aes_key_q <= aes_key;
    end
  end
`else
  logic unused_aes_key;
  assign unused_aes_key = ^aes_key;
`endif

  // Next payload byte to present: index 0 after LEN, otherwise idx+1.
  always_comb begin
    rd_addr  = (state == SEND_LEN) ? '0 : AW'(idx + 8'd1);
    pay_next = buffer[rd_addr];
`ifdef SECURE_TX_FRAMER_SCRAMBLE_EN
    key_sel  = (state == SEND_LEN) ? 4'd0 : 4'(idx + 8'd1);
    pay_next = pay_next ^ aes_key_q[{key_sel, 3'b000} +: 8];
`endif
  end

  // Payload buffer: plain storage, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[count[AW-1:0]] <= s_data;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d        = state;
    count_d        = count;
    idx_d          = idx;
    crc_d          = crc;
    seen_low_d     = seen_low;
    key_gen_d      = 1'b0;
    s_ready_d      = 1'b0;
    m_valid_d      = m_valid;
    m_data_d       = m_data;
    frame_busy_d   = frame_busy;
    err_overflow_d = 1'b0;
    buf_we         = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_d      = REQ_KEY;
          frame_busy_d = 1'b1;
          count_d      = 8'd0;
          idx_d        = 8'd0;
        end
      end
      REQ_KEY: begin
        key_gen_d  = 1'b1;
        seen_low_d = 1'b0;
        state_d    = KEY_WAIT;
      end
      KEY_WAIT: begin
        // A key_valid still high from the previous key must first be seen low.
        if (!key_valid) begin
          seen_low_d = 1'b1;
        end else if (seen_low) begin
          crc_d     = crc_key;
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
      LOAD: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready) begin
          buf_we  = 1'b1;
          count_d = count_inc[7:0];
          if (s_last || count_inc == MAX_LEN9) begin
            s_ready_d      = 1'b0;
            err_overflow_d = !s_last;
            state_d        = SEND_SOF;
            m_valid_d      = 1'b1;
            m_data_d       = SOF_BYTE;
          end
        end
      end
      SEND_SOF: begin
        if (m_valid && m_ready) begin
          state_d  = SEND_LEN;
          m_data_d = count;
        end
      end
      SEND_LEN: begin
        if (m_valid && m_ready) begin
          state_d  = SEND_PAY;
          idx_d    = 8'd0;
          m_data_d = pay_next;
        end
      end
      SEND_PAY: begin
        if (m_valid && m_ready) begin
          crc_d = crc_nxt;
          if (idx + 8'd1 == count) begin
            state_d  = SEND_CRC_H;
            m_data_d = crc_nxt[15:8];
          end else begin
            idx_d    = idx + 8'd1;
            m_data_d = pay_next;
          end
        end
      end
      SEND_CRC_H: begin
        if (m_valid && m_ready) begin
          state_d  = SEND_CRC_L;
          m_data_d = crc[7:0];
        end
      end
      SEND_CRC_L: begin
        if (m_valid && m_ready) begin
          state_d      = IDLE;
          m_valid_d    = 1'b0;
          frame_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 8'd0;
      idx          <= 8'd0;
      crc          <= 16'd0;
      seen_low     <= 1'b0;
      key_gen      <= 1'b0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= 8'd0;
      frame_busy   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      idx          <= idx_d;
      crc          <= crc_d;
      seen_low     <= seen_low_d;
      key_gen      <= key_gen_d;
      s_ready      <= s_ready_d;
      m_valid      <= m_valid_d;
      m_data       <= m_data_d;
      frame_busy   <= frame_busy_d;
      err_overflow <= err_overflow_d;
    end
  end

endmodule

// File: tb/tb_secure_tx_framer.sv
// tb/tb_secure_tx_framer.sv - directed self-checking bench for secure_tx_framer
module tb_secure_tx_framer;

  typedef logic [7:0] bq_t [$];

`ifdef SECURE_TX_FRAMER_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid;
  logic [15:0]  crc_key;
  logic [127:0] aes_key;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         m_ready;
  logic         sel;
  logic         bp_mode;
  logic [15:0]  next_seed;

  logic       a_key_gen, a_s_ready, a_m_valid, a_frame_busy, a_err_overflow;
  logic [7:0] a_m_data;
  logic       b_key_gen, b_s_ready, b_m_valid, b_frame_busy, b_err_overflow;
  logic [7:0] b_m_data;
  logic       key_gen_s, s_ready_s, m_valid_s, frame_busy_s, err_overflow_s;
  logic [7:0] m_data_s;

  int   errors = 0;
  int   checks = 0;
  int   kg_count = 0;
  int   ov_count = 0;
  int   stall_err = 0;
  bq_t  rx;

  initial forever #5 clk = ~clk;

  secure_tx_framer #(.MAX_LEN(16), .SOF_BYTE(8'h7E)) dut (
    .clk(clk), .rst_n(rst_n), .key_gen(a_key_gen), .key_valid(key_valid),
    .crc_key(crc_key), .aes_key(aes_key), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid),
    .m_ready(m_ready), .frame_busy(a_frame_busy), .err_overflow(a_err_overflow)
  );

  secure_tx_framer #(.MAX_LEN(4), .SOF_BYTE(8'h7E)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_gen(b_key_gen), .key_valid(key_valid),
    .crc_key(crc_key), .aes_key(aes_key), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid),
    .m_ready(m_ready), .frame_busy(b_frame_busy), .err_overflow(b_err_overflow)
  );

  assign key_gen_s      = sel ? b_key_gen      : a_key_gen;
  assign s_ready_s      = sel ? b_s_ready      : a_s_ready;
  assign m_valid_s      = sel ? b_m_valid      : a_m_valid;
  assign m_data_s       = sel ? b_m_data       : a_m_data;
  assign frame_busy_s   = sel ? b_frame_busy   : a_frame_busy;
  assign err_overflow_s = sel ? b_err_overflow : a_err_overflow;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int b = 7; b >= 0; b--) begin
      if (c[15] ^ d[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic bq_t mk_frame(input bq_t pay, input logic [15:0] seed, input bit scr);
    bq_t         fr;
    logic [15:0] c;
    logic [7:0]  b;
    fr = {8'h7E, 8'(pay.size())};
    c  = seed;
    for (int i = 0; i < pay.size(); i++) begin
      b = pay[i] ^ (scr ? aes_key[8*(i%16) +: 8] : 8'h00);
      fr.push_back(b);
      c = ref_crc(c, b);
    end
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
    return fr;
  endfunction

  // Key generator model: drops key_valid 2 cycles after key_gen, re-raises it with next_seed later.
  initial begin
    int kcnt;
    kcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        kcnt = 0;
      end else begin
        if (key_gen_s) kg_count++;
        if (kcnt == 0 && key_gen_s) begin
          kcnt = 1;
        end else if (kcnt > 0) begin
          kcnt++;
          if (kcnt == 3) key_valid = 1'b0;
          if (kcnt == 6) begin
            key_valid = 1'b1;
            crc_key   = next_seed;
            kcnt      = 0;
          end
        end
      end
    end
  end

  // Output monitor: collects accepted bytes, counts overflow pulses, checks stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!m_valid_s || m_data_s !== prev_data)) stall_err++;
        if (m_valid_s && m_ready) rx.push_back(m_data_s);
        if (err_overflow_s) ov_count++;
        prev_stall = m_valid_s && !m_ready;
        prev_data  = m_data_s;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rx.delete();
    kg_count  = 0;
    ov_count  = 0;
    stall_err = 0;
  endtask

  task automatic send_bytes(input bq_t pay, input bit use_last);
    int n;
    for (int i = 0; i < pay.size(); i++) begin
      s_valid = 1'b1;
      s_data  = pay[i];
      s_last  = use_last && (i == pay.size() - 1);
      n = 0;
      @(negedge clk);
      while (!s_ready_s && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        check("s_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_stream(input bq_t exp, input string tag);
    int n;
    n = 0;
    while (rx.size() < exp.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_len"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), rx[i], exp[i]);
    end
    rx.delete();
  endtask

  initial begin
    bq_t digits, basic_exp, alt_exp, stale_exp, ov_pay, ov_exp, scr_pay, scr_exp;
    int  n;
    digits    = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    basic_exp = {8'h7E, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    alt_exp   = {8'h7E, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
    stale_exp = {8'h7E, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hE5, 8'hCC};
    key_valid = 1'b1;
    crc_key   = 16'hDEAD;
    aes_key   = 128'h0F0E0D0C0B0A09080706050403020100;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    sel       = 1'b0;
    bp_mode   = 1'b0;
    next_seed = 16'hFFFF;

    repeat (2) @(posedge clk);
    #1 check("reset_outputs", {19'd0, key_gen_s, s_ready_s, m_valid_s, frame_busy_s, err_overflow_s, m_data_s}, 32'd0);
    rst_n = 1'b1;

    // Basic frame, seed FFFF.
    send_bytes(digits, 1'b1);
    expect_stream(basic_exp, "basic");
    check("basic_busy_low", frame_busy_s, 1'b0);
    check("basic_key_gen_pulses", kg_count, 1);

    // Alternate seed 0000.
    do_reset();
    next_seed = 16'h0000;
    send_bytes(digits, 1'b1);
    expect_stream(alt_exp, "alt_seed");

    // Stale key_valid (still high with 0000) must not be used; new seed is 1D0F.
    do_reset();
    next_seed = 16'h1D0F;
    send_bytes(digits, 1'b1);
    expect_stream(stale_exp, "stale_key");

    // Overflow at MAX_LEN=4; A4..A6 form the second frame, closed by s_last on A6.
    do_reset();
    sel       = 1'b1;
    next_seed = 16'hFFFF;
    ov_pay    = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_bytes(ov_pay, 1'b1);
    ov_exp    = {mk_frame({8'hA0, 8'hA1, 8'hA2, 8'hA3}, 16'hFFFF, 1'b0),
                 mk_frame({8'hA4, 8'hA5, 8'hA6}, 16'hFFFF, 1'b0)};
    expect_stream(ov_exp, "overflow");
    check("overflow_pulses", ov_count, 1);
    check("overflow_key_gen_pulses", kg_count, 2);
    sel = 1'b0;

    // Random backpressure: same bytes, stable while stalled.
    do_reset();
    bp_mode = 1'b1;
    send_bytes(digits, 1'b1);
    expect_stream(basic_exp, "backpressure");
    check("stall_stability", stall_err, 0);
    bp_mode = 1'b0;

    // Reset during SEND_PAY, then a clean frame.
    do_reset();
    send_bytes(digits, 1'b1);
    n = 0;
    while (rx.size() < 4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("midreset_reached_pay", 32'(rx.size() >= 4), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("midreset_outputs", {19'd0, key_gen_s, s_ready_s, m_valid_s, frame_busy_s, err_overflow_s, m_data_s}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx.delete();
    send_bytes(digits, 1'b1);
    expect_stream(basic_exp, "after_reset");

    // Payload 00 00: scrambled to 00 01 when the feature is built in, plain otherwise.
    do_reset();
    scr_pay = {8'h00, 8'h00};
    send_bytes(scr_pay, 1'b1);
    scr_exp = mk_frame(scr_pay, 16'hFFFF, SCR);
    expect_stream(scr_exp, "scramble");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
